// File: rtl/time_counter_pkg.sv
// Shared types and constants for the time-of-day counter.
package time_counter_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd2_t;

  localparam int SEC_LIMIT = 59;
  localparam int MIN_LIMIT = 59;

  // Legal values for the hour wrap point: 24-hour and 12-hour display.
  localparam int HOUR_MAX_24 = 23;
  localparam int HOUR_MAX_12 = 11;

  // Converts a binary value 0..99 into its two-digit BCD form.
  function automatic bcd2_t to_bcd2(input int value);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = bcd_digit_t'(value / 10);
    units = bcd_digit_t'(value % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that counts 00..LIMIT and wraps to 00.
// carry is combinational so a chain of these can cascade in one cycle.
module bcd2_counter
  import time_counter_pkg::*;
#(
  parameter int LIMIT = SEC_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  localparam bcd2_t LIMIT_BCD = to_bcd2(LIMIT);

  bcd_digit_t tens_q;
  bcd_digit_t units_q;
  bcd_digit_t tens_d;
  bcd_digit_t units_d;
  logic       at_limit;

  assign at_limit = ({tens_q, units_q} == LIMIT_BCD);
  assign carry    = inc & at_limit;
  assign value    = {tens_q, units_q};

  // Next digit values: wrap at LIMIT, roll tens when units reach 9.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    tens_d  = tens_q;
    units_d = units_q;
    if (inc) begin
      if (at_limit) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = '0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous reset and clear.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!reset) begin
      tens_q  <= '0;
      units_q <= '0;
    end else if (clr) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter (hh:mm:ss in BCD) advanced by rising edges of an
// upstream divider square wave. While stopped, minutes and hours can be
// stepped by single-cycle set pulses. HOUR_MAX selects 24h (23) or 12h (11).
module time_counter
  import time_counter_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       run,
  input  logic       clr,
  input  logic       set_min,
  input  logic       set_hr,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       sec_pulse,
  output logic       day_wrap
);

  logic tick_q;
  logic tick_q_valid;
  logic tick_det;
  logic sec_inc;
  logic min_inc;
  logic hr_inc;
  logic sec_carry;
  logic min_carry;
  logic hr_carry;

  // Tick history: tick_q_valid stays low for the first cycle after reset so a
  // level already high at release is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q       <= 1'b0;
      tick_q_valid <= 1'b0;
    end else begin
      tick_q       <= tick_in;
      tick_q_valid <= 1'b1;
    end
  end

  assign tick_det = tick_in & ~tick_q & tick_q_valid;

  // Priority: clr beats set pulses, which beat ticks. Set pulses only act
  // while stopped and never propagate a carry into the next field.
  assign sec_inc = run & ~clr & tick_det;
  assign min_inc = ~clr & (run ? sec_carry : set_min);
  assign hr_inc  = ~clr & (run ? min_carry : set_hr);

  bcd2_counter #(.LIMIT(SEC_LIMIT)) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .clr   (clr),
    .value (sec_bcd),
    .carry (sec_carry)
  );

  bcd2_counter #(.LIMIT(MIN_LIMIT)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .clr   (clr),
    .value (min_bcd),
    .carry (min_carry)
  );

  bcd2_counter #(.LIMIT(HOUR_MAX)) u_hr (
    .clk   (clk),
    .reset (reset),
    .inc   (hr_inc),
    .clr   (clr),
    .value (hr_bcd),
    .carry (hr_carry)
  );

  // Registered strobes; day_wrap only for a counted rollover, not a set pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      sec_pulse <= sec_inc;
      day_wrap  <= hr_carry & run;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: a 24-hour and a 12-hour instance share
// the same stimulus; a behavioural model (seconds-of-day arithmetic) queues
// the expected outputs after every edge and a monitor compares them.
module tb_time_counter;
  import time_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic run = 1'b0;
  logic clr = 1'b0;
  logic set_min = 1'b0;
  logic set_hr = 1'b0;
  logic tick_in = 1'b0;

  logic [7:0] sec24, min24, hr24, sec12, min12, hr12;
  logic       sp24, dw24, sp12, dw12;

  time_counter #(.HOUR_MAX(23)) dut24 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .clr(clr),
    .set_min(set_min), .set_hr(set_hr),
    .sec_bcd(sec24), .min_bcd(min24), .hr_bcd(hr24),
    .sec_pulse(sp24), .day_wrap(dw24)
  );

  time_counter #(.HOUR_MAX(11)) dut12 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .clr(clr),
    .set_min(set_min), .set_hr(set_hr),
    .sec_bcd(sec12), .min_bcd(min12), .hr_bcd(hr12),
    .sec_pulse(sp12), .day_wrap(dw12)
  );

  typedef struct {
    logic [7:0] s;
    logic [7:0] m;
    logic [7:0] h;
    logic       sp;
    logic       dw;
  } exp_t;

  exp_t q24[$];
  exp_t q12[$];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: plain integers per instance.
  int   ms[2];
  int   mm[2];
  int   mh[2];
  int   hour_top[2] = '{23, 11};
  logic m_sp[2];
  logic m_dw[2];
  logic prev_tick = 1'b0;
  logic prev_known = 1'b0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at time %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules to the inputs currently driven, giving the state after the next edge.
  task automatic model_step();
    logic rose;
    int   total;
    int   period;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        ms[i] = 0; mm[i] = 0; mh[i] = 0; m_sp[i] = 1'b0; m_dw[i] = 1'b0;
      end
      prev_tick  = 1'b0;
      prev_known = 1'b0;
    end else begin
      rose       = tick_in && prev_known && !prev_tick;
      prev_tick  = tick_in;
      prev_known = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_sp[i] = 1'b0;
        m_dw[i] = 1'b0;
        if (clr) begin
          ms[i] = 0; mm[i] = 0; mh[i] = 0;
        end else if (!run) begin
          if (set_min) mm[i] = (mm[i] + 1) % 60;
          if (set_hr)  mh[i] = (mh[i] + 1) % (hour_top[i] + 1);
        end else if (rose) begin
          period = (hour_top[i] + 1) * 3600;
          total  = mh[i] * 3600 + mm[i] * 60 + ms[i] + 1;
          m_sp[i] = 1'b1;
          if (total == period) begin
            total   = 0;
            m_dw[i] = 1'b1;
          end
          ms[i] = total % 60;
          mm[i] = (total / 60) % 60;
          mh[i] = total / 3600;
        end
      end
    end
  endtask

  // One clock cycle of stimulus; the expected result is queued after the edge.
  task automatic cyc(input logic r, input logic ru, input logic c,
                     input logic sm, input logic sh, input logic tk);
    reset = r; run = ru; clr = c; set_min = sm; set_hr = sh; tick_in = tk;
    model_step();
    @(posedge clk);
    q24.push_back('{s: bcd(ms[0]), m: bcd(mm[0]), h: bcd(mh[0]), sp: m_sp[0], dw: m_dw[0]});
    q12.push_back('{s: bcd(ms[1]), m: bcd(mm[1]), h: bcd(mh[1]), sp: m_sp[1], dw: m_dw[1]});
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc(1'b1, run, 1'b0, 1'b0, 1'b0, tick_in);
  endtask

  task automatic tick1();
    cyc(1'b1, run, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, run, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_pulse(input logic sm, input logic sh);
    cyc(1'b1, 1'b0, 1'b0, sm, sh, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_all();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q24.size() > 0) begin
      e = q24.pop_front();
      check("sec24", sec24, e.s);
      check("min24", min24, e.m);
      check("hr24", hr24, e.h);
      check("sec_pulse24", {7'd0, sp24}, {7'd0, e.sp});
      check("day_wrap24", {7'd0, dw24}, {7'd0, e.dw});
    end
    if (q12.size() > 0) begin
      e = q12.pop_front();
      check("sec12", sec12, e.s);
      check("min12", min12, e.m);
      check("hr12", hr12, e.h);
      check("sec_pulse12", {7'd0, sp12}, {7'd0, e.sp});
      check("day_wrap12", {7'd0, dw12}, {7'd0, e.dw});
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic rnd_run;
    logic rnd_tick;

    // Reset state.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three edges 50 cycles apart.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (25) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (25) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("three_ticks_sec", sec24, 8'h03);

    // Preload 23:59:59 (12h instance reaches 11:59:59), then one tick wraps the day.
    clear_all();
    repeat (23) set_pulse(1'b0, 1'b1);
    repeat (59) set_pulse(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (59) tick1();
    check("preload_hr24", hr24, 8'h23);
    check("preload_hr12", hr12, 8'h11);
    tick1();
    check("wrap_hr24", hr24, 8'h00);
    check("wrap_min24", min24, 8'h00);
    hold(3);

    // Hours set past 11 on the 12h instance wraps without day_wrap.
    clear_all();
    repeat (11) set_pulse(1'b0, 1'b1);
    set_pulse(1'b0, 1'b1);
    check("set_hr_wrap12", hr12, 8'h00);
    check("set_hr_24", hr24, 8'h12);

    // Minutes set past 59 leaves hours alone; set pulses ignored while running.
    clear_all();
    repeat (3) set_pulse(1'b0, 1'b1);
    repeat (59) set_pulse(1'b1, 1'b0);
    set_pulse(1'b1, 1'b0);
    check("set_min_wrap", min24, 8'h00);
    check("set_min_hr_kept", hr24, 8'h03);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_pulse(1'b1, 1'b1);

    // clr coincident with a tick edge at 00:00:42, then tick_in held high.
    clear_all();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (42) tick1();
    check("pre_clr_sec", sec24, 8'h42);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_tick_sec", sec24, 8'h00);

    // Reset mid-count at 05:17:33 with tick_in high, released while still high.
    clear_all();
    repeat (5) set_pulse(1'b0, 1'b1);
    repeat (17) set_pulse(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (33) tick1();
    check("pre_reset_min", min24, 8'h17);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_release_sec", sec24, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick1();
    check("after_release_sec", sec24, 8'h01);

    // Randomized phase.
    rnd_run  = 1'b1;
    rnd_tick = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) rnd_run = ~rnd_run;
      if ($urandom_range(0, 2) == 0) rnd_tick = ~rnd_tick;
      cyc(($urandom_range(0, 299) != 0), rnd_run, ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), rnd_tick);
    end

    hold(2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
